// File: rtl/piso_serializer_hs_pkg.sv
// piso_pkg: shared types and constants for the PISO serializer.
// No ports; provides state enum, clog2 helper and default width.
package piso_pkg;

  // Shared with the downstream 8-bit capture register.
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer_hs_if.sv
// Word-in / bit-out handshake bundle of the serializer.
// master: upstream+downstream side; slave: the serializer.
interface piso_serializer_hs_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] DIN;
  logic             DIN_VALID;
  logic             DIN_READY;
  logic             SO;
  logic             SO_VALID;
  logic             SO_LAST;

  modport master (
    output DIN,
    output DIN_VALID,
    input  DIN_READY,
    input  SO,
    input  SO_VALID,
    input  SO_LAST
  );

  modport slave (
    input  DIN,
    input  DIN_VALID,
    output DIN_READY,
    output SO,
    output SO_VALID,
    output SO_LAST
  );

endinterface

// File: rtl/piso_serializer_hs_bit_counter.sv
// piso_bit_counter: loadable down-counter, load value WIDTH-1.
// Ports: clk, rst_n, load, dec, cnt (bits left), zero flag.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CW    = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WIDTH - 1);
    end else if (dec && !zero) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer_hs.sv
// piso_serializer_hs: valid/ready word in, one bit per EN cycle out.
// Ports: C, CLR_N, EN, bus (DIN/DIN_VALID/DIN_READY/SO/SO_VALID/SO_LAST).
module piso_serializer_hs
  import piso_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CW        = clog2(WIDTH)
) (
  input  logic                 C,
  input  logic                 CLR_N,
  input  logic                 EN,
  piso_serializer_hs_if.slave  bus
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             zero;
  logic             ready;
  logic             xfer;
  logic             busy;

  assign busy  = (state == SHIFT);
  assign ready = EN && (!busy || (busy && zero));
  assign xfer  = bus.DIN_VALID && ready;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (C),
    .rst_n (CLR_N),
    .load  (xfer),
    .dec   (EN && busy),
    .cnt   (cnt),
    .zero  (zero)
  );

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (EN && zero && !xfer) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  // Cleared after the last bit so SO reads 0 in IDLE
  // straight from the register.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      sreg <= '0;
    end else if (xfer) begin
      sreg <= bus.DIN;
    end else if (EN && busy) begin
      sreg <= zero ? '0 : shifted;
    end
  end

  assign bus.DIN_READY = ready;
  assign bus.SO        = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign bus.SO_VALID  = busy;
  assign bus.SO_LAST   = busy && zero;

endmodule

// File: tb/tb_piso_serializer_hs.sv
// Scoreboard bench for piso_serializer_hs (8-bit MSB-first
// plus a 4-bit LSB-first instance).
module tb_piso_serializer_hs;
  import piso_pkg::*;

  typedef struct {
    bit b;
    bit last;
  } exp_t;

  logic C     = 1'b0;
  logic CLR_N = 1'b1;
  logic EN    = 1'b1;
  logic EN4   = 1'b1;
  bit   rand_en  = 1'b0;
  bit   en_force = 1'b1;

  piso_serializer_hs_if #(.WIDTH(8)) bus ();
  piso_serializer_hs_if #(.WIDTH(4)) bus4 ();

  piso_serializer_hs #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) dut (
    .C     (C),
    .CLR_N (CLR_N),
    .EN    (EN),
    .bus   (bus)
  );

  piso_serializer_hs #(
    .WIDTH     (4),
    .MSB_FIRST (1'b0)
  ) dut4 (
    .C     (C),
    .CLR_N (CLR_N),
    .EN    (EN4),
    .bus   (bus4)
  );

  always #5 C = ~C;

  always @(posedge C) begin
    #2;
    EN = rand_en ? ($urandom_range(0, 3) != 0) : en_force;
  end

  exp_t       q[$];
  logic [7:0] wq[$];
  exp_t       e;
  logic [7:0] w;
  logic [7:0] sipo = '0;
  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int run_len  = 0;
  int prev_run = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, req, $time);
    end
  endtask

  // Posedge: record accepted words as expected bit streams.
  // Negedge: compare presented bits against the model.
  always @(posedge C or negedge C) begin
    if (C) begin
      if (CLR_N && bus.DIN_VALID && bus.DIN_READY) begin
        for (int i = 7; i >= 0; i--) begin
          q.push_back('{b: bus.DIN[i], last: (i == 0)});
        end
        wq.push_back(bus.DIN);
        xfers++;
      end
    end else if (!CLR_N) begin
      q.delete();
      wq.delete();
      run_len = 0;
    end else begin
      chk("din_ready", bus.DIN_READY, EN && (q.size() <= 1));
      if (bus.SO_VALID) begin
        run_len++;
        chk("bit_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("so", bus.SO, q[0].b);
          chk("so_last", bus.SO_LAST, q[0].last);
          if (EN) begin
            e = q.pop_front();
            sipo = {sipo[6:0], bus.SO};
            if (e.last && wq.size() != 0) begin
              w = wq.pop_front();
              chk("sipo_po", sipo, w);
            end
          end
        end
      end else begin
        if (run_len != 0) prev_run = run_len;
        run_len = 0;
        chk("idle_so", {bus.SO, bus.SO_LAST}, 0);
        chk("idle_queue", q.size(), 0);
      end
    end
  end

  task automatic send(input logic [7:0] wd);
    int n;
    n = 0;
    bus.DIN = wd;
    bus.DIN_VALID = 1'b1;
    do begin
      @(negedge C);
      n++;
    end while (!bus.DIN_READY && n < 300);
    chk("send_ready", bus.DIN_READY, 1);
    @(posedge C);
    #1;
    bus.DIN_VALID = 1'b0;
    bus.DIN = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge C);
      n++;
    end while ((q.size() != 0 || bus.SO_VALID) && n < 1000);
    chk("idle_reached", (q.size() != 0) || bus.SO_VALID, 0);
    @(posedge C);
    #1;
  endtask

  initial begin
    int x0;
    logic [3:0] w4;
    bus.DIN = '0;
    bus.DIN_VALID = 1'b0;
    bus4.DIN = '0;
    bus4.DIN_VALID = 1'b0;
    #1 CLR_N = 1'b0;
    #1;
    chk("rst_so", bus.SO, 0);
    chk("rst_valid", bus.SO_VALID, 0);
    chk("rst_last", bus.SO_LAST, 0);
    chk("rst_ready", bus.DIN_READY, 1);
    #11 CLR_N = 1'b1;
    @(posedge C);
    #1;

    // 4-bit LSB-first
    w4 = 4'b1101;
    bus4.DIN = w4;
    bus4.DIN_VALID = 1'b1;
    @(negedge C);
    chk("w4_ready", bus4.DIN_READY, 1);
    @(posedge C);
    #1;
    bus4.DIN_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge C);
      chk("w4_valid", bus4.SO_VALID, 1);
      chk("w4_so", bus4.SO, w4[i]);
      chk("w4_last", bus4.SO_LAST, (i == 3));
    end
    @(negedge C);
    chk("w4_idle", bus4.SO_VALID, 0);
    @(posedge C);
    #1;

    // single word
    x0 = xfers;
    send(8'hA5);
    wait_idle();
    chk("a5_run", prev_run, 8);
    chk("a5_xfers", xfers - x0, 1);

    // back-to-back
    x0 = xfers;
    send(8'h3C);
    send(8'hC3);
    wait_idle();
    chk("b2b_run", prev_run, 16);
    chk("b2b_xfers", xfers - x0, 2);

    // stall after 3rd bit
    send(8'hF0);
    @(posedge C);
    #1;
    @(posedge C);
    #1;
    en_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge C);
      chk("stall_so", bus.SO, 1);
      chk("stall_valid", bus.SO_VALID, 1);
      chk("stall_ready", bus.DIN_READY, 0);
    end
    en_force = 1'b1;
    wait_idle();
    chk("stall_run", prev_run, 11);

    // early DIN_VALID
    x0 = xfers;
    send(8'hFF);
    @(posedge C);
    #1;
    bus.DIN = 8'h55;
    bus.DIN_VALID = 1'b1;
    @(negedge C);
    chk("early_not_ready", bus.DIN_READY, 0);
    send(8'h55);
    wait_idle();
    chk("early_xfers", xfers - x0, 2);
    chk("early_run", prev_run, 16);

    // reset mid-word
    send(8'h81);
    repeat (3) @(posedge C);
    #3 CLR_N = 1'b0;
    #1;
    chk("mid_rst_so", bus.SO, 0);
    chk("mid_rst_valid", bus.SO_VALID, 0);
    chk("mid_rst_last", bus.SO_LAST, 0);
    chk("mid_rst_ready", bus.DIN_READY, 1);
    @(negedge C);
    #2 CLR_N = 1'b1;
    @(posedge C);
    #1;
    chk("post_rst_ready", bus.DIN_READY, 1);
    chk("post_rst_valid", bus.SO_VALID, 0);
    send(8'h01);
    wait_idle();
    chk("post_rst_run", prev_run, 8);

    // randomized traffic with random EN
    rand_en = 1'b1;
    repeat (40) begin
      send(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge C);
        #1;
      end
    end
    rand_en = 1'b0;
    wait_idle();
    chk("words_drained", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
